// File: rtl/time_digit_set_pkg.sv
// Shared set-time state encodings, digit limits and digit-select decode.
// Also used by the set-time sequencer.
package time_digit_set_pkg;

  typedef enum logic [6:0] {
    ST_BASE   = 7'b0000001,
    ST_HOUR10 = 7'b0000010,
    ST_HOUR1  = 7'b0000100,
    ST_MIN10  = 7'b0001000,
    ST_MIN1   = 7'b0010000,
    ST_SEC10  = 7'b0100000,
    ST_SEC1   = 7'b1000000
  } set_state_e;

  localparam int H10_MAX   = 2;
  localparam int H1_MAX    = 9;
  localparam int H1_MAX_20 = 3;
  localparam int M10_MAX   = 5;
  localparam int M1_MAX    = 9;
  localparam int S10_MAX   = 5;
  localparam int S1_MAX    = 9;

  localparam int D_H10 = 5;
  localparam int D_H1  = 4;
  localparam int D_M10 = 3;
  localparam int D_M1  = 2;
  localparam int D_S10 = 1;
  localparam int D_S1  = 0;

  // Anything that is not a digit state (incl. non-one-hot) selects nothing.
  function automatic logic [5:0] digit_sel(input logic [6:0] st);
    case (st)
      ST_BASE:   digit_sel = 6'b000000;
      ST_HOUR10: digit_sel = 6'b100000;
      ST_HOUR1:  digit_sel = 6'b010000;
      ST_MIN10:  digit_sel = 6'b001000;
      ST_MIN1:   digit_sel = 6'b000100;
      ST_SEC10:  digit_sel = 6'b000010;
      ST_SEC1:   digit_sel = 6'b000001;
      default:   digit_sel = 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/time_digit_set_bcd_digit_cnt.sv
// Single BCD digit counter with wrap, clear, load and dynamic limit.
module bcd_digit_cnt #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         ovr_i,
  input  logic [W-1:0] max_ovr_i,
  output logic [W-1:0] value_o,
  output logic         carry_o
);

  logic [W-1:0] val_q, val_d, lim;

  assign lim     = ovr_i ? max_ovr_i : W'(MAX);
  assign carry_o = inc_i && (val_q >= lim);
  assign value_o = val_q;

  always_comb begin
    val_d = val_q;
    if (clr_i)      val_d = '0;
    else if (ld_i)  val_d = ld_val_i;
    else if (inc_i) val_d = carry_o ? '0 : val_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

endmodule

// File: rtl/time_digit_set.sv
// HH:MM:SS BCD time keeper with run/set modes and day carry.
// Optional per-digit blink request under TIME_DIGIT_SET_BLINK_EN.
module time_digit_set
  import time_digit_set_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       EN_1HZ,
  input  logic       SEL_MODE0,
  input  logic [6:0] CURRENT_STATE_TIME,
  input  logic       BAP_BTN3,
  output logic [1:0] HOUR10,
  output logic [3:0] HOUR1,
  output logic [2:0] MIN10,
  output logic [3:0] MIN1,
  output logic [2:0] SEC10,
  output logic [3:0] SEC1,
  output logic       DAY_CARRY
`ifdef TIME_DIGIT_SET_BLINK_EN
  ,
  output logic [5:0] DIGIT_BLANK
`endif
);

  logic       run, tick;
  logic [5:0] sel, set_inc;
  logic       c_s1, c_s10, c_m1, c_m10, c_h1, c_h10;
  logic       h1_ld, h1_ovr;
  logic       dc_q, dc_d;

  assign run     = ~SEL_MODE0;
  assign tick    = run & EN_1HZ;
  assign sel     = digit_sel(CURRENT_STATE_TIME);
  assign set_inc = (SEL_MODE0 & BAP_BTN3) ? sel : '0;

  // Entering the 20s from 1x clamps HOUR1 so the hour stays legal.
  assign h1_ovr = (HOUR10 == 2'(H10_MAX));
  assign h1_ld  = set_inc[D_H10] && (HOUR10 == 2'd1)
                  && (HOUR1 > 4'(H1_MAX_20));

  bcd_digit_cnt #(.W(4), .MAX(S1_MAX)) u_s1 (
    .clk(CLK), .rst_n(RESET_N),
    .inc_i(tick | set_inc[D_S1]), .clr_i(1'b0),
    .ld_i(1'b0), .ld_val_i(4'd0),
    .ovr_i(1'b0), .max_ovr_i(4'd0),
    .value_o(SEC1), .carry_o(c_s1)
  );

  bcd_digit_cnt #(.W(3), .MAX(S10_MAX)) u_s10 (
    .clk(CLK), .rst_n(RESET_N),
    .inc_i((run & c_s1) | set_inc[D_S10]), .clr_i(1'b0),
    .ld_i(1'b0), .ld_val_i(3'd0),
    .ovr_i(1'b0), .max_ovr_i(3'd0),
    .value_o(SEC10), .carry_o(c_s10)
  );

  bcd_digit_cnt #(.W(4), .MAX(M1_MAX)) u_m1 (
    .clk(CLK), .rst_n(RESET_N),
    .inc_i((run & c_s10) | set_inc[D_M1]), .clr_i(1'b0),
    .ld_i(1'b0), .ld_val_i(4'd0),
    .ovr_i(1'b0), .max_ovr_i(4'd0),
    .value_o(MIN1), .carry_o(c_m1)
  );

  bcd_digit_cnt #(.W(3), .MAX(M10_MAX)) u_m10 (
    .clk(CLK), .rst_n(RESET_N),
    .inc_i((run & c_m1) | set_inc[D_M10]), .clr_i(1'b0),
    .ld_i(1'b0), .ld_val_i(3'd0),
    .ovr_i(1'b0), .max_ovr_i(3'd0),
    .value_o(MIN10), .carry_o(c_m10)
  );

  bcd_digit_cnt #(.W(4), .MAX(H1_MAX)) u_h1 (
    .clk(CLK), .rst_n(RESET_N),
    .inc_i((run & c_m10) | set_inc[D_H1]), .clr_i(1'b0),
    .ld_i(h1_ld), .ld_val_i(4'(H1_MAX_20)),
    .ovr_i(h1_ovr), .max_ovr_i(4'(H1_MAX_20)),
    .value_o(HOUR1), .carry_o(c_h1)
  );

  bcd_digit_cnt #(.W(2), .MAX(H10_MAX)) u_h10 (
    .clk(CLK), .rst_n(RESET_N),
    .inc_i((run & c_h1) | set_inc[D_H10]), .clr_i(1'b0),
    .ld_i(1'b0), .ld_val_i(2'd0),
    .ovr_i(1'b0), .max_ovr_i(2'd0),
    .value_o(HOUR10), .carry_o(c_h10)
  );

  assign dc_d      = run & c_h10;
  assign DAY_CARRY = dc_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) dc_q <= 1'b0;
    else          dc_q <= dc_d;
  end

`ifdef TIME_DIGIT_SET_BLINK_EN
  logic       phase_q, phase_d;
  logic [5:0] blank_q, blank_d;

  assign phase_d     = phase_q ^ EN_1HZ;
  assign blank_d     = (SEL_MODE0 && phase_d) ? sel : '0;
  assign DIGIT_BLANK = blank_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q <= 1'b0;
      blank_q <= '0;
    end else begin
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end
`endif

endmodule
